video_sync_detect: RTL and testbench
====================================

// Module: video_sync_detect
// PURPOSE
// Receive-side counterpart of the video sync generator: takes external HSYNC/VSYNC (async pins),
// detects each polarity, measures line period, hsync width and lines per frame in pix_stb units,
// and flags lock. Feeds mode detection/OSD so the loader can tell TV 15kHz from VGA 31kHz timing.
// PARAMETERS
// H_W          9     width of horizontal counters (pix_stb units, saturating)
// V_W          10    width of vertical line counter (saturating)
// POL_WIN_LOG  10   polarity window = 2**POL_WIN_LOG samples (H: pix_stb, V: lines)
// H_MIN        64    smallest h_period accepted for lock
// V_MIN        128   smallest v_period accepted for lock
// H_LOCK_N     4     consecutive matching lines needed for h lock
// V_LOCK_N     2     consecutive matching frames needed for v lock
// PORTS
// clk            in   1    system clock (same clock as the sync generator)
// rst            in   1    asynchronous reset, active high
// pix_stb        in   1    pixel strobe, 1-clk pulse; all measurement advances only on it
// hsync_in       in   1    external HSYNC, asynchronous, either polarity
// vsync_in       in   1    external VSYNC, asynchronous, either polarity
// hsync_pol      out  1    1 = positive (active high) hsync, 0 = negative
// vsync_pol      out  1    1 = positive vsync, 0 = negative
// h_period       out  H_W  pix_stb count between active hsync leading edges
// h_sync_len     out  H_W  pix_stb count hsync held active
// v_period       out  V_W  line count between active vsync leading edges
// locked         out  1    h and v timing both stable
// new_frame      out  1    1-clk pulse on each accepted vsync leading edge
// BEHAVIOUR
// - Reset: hsync_pol=0, vsync_pol=0, h_period=0, h_sync_len=0, v_period=0, locked=0, new_frame=0;
//   all internal counters and lock-run counters cleared. Reset mid-measurement discards partial data.
// - Inputs pass a 2-FF synchronizer every clk; edge detect on 3rd stage; edges are acted on at the
//   next pix_stb (edge flag held until consumed). Latency pin->h counter restart: <=3 clk + 1 pix_stb.
// - Polarity: count pix_stb with hsync high over 2**POL_WIN_LOG pix_stb; at window end
//   hsync_pol <= (high_cnt < half window). Same for vsync sampled once per active hsync edge, window in lines.
//   Exactly half -> polarity unchanged. Polarity change clears lock runs and locked.
// - Active level = sync ~^ pol. Leading edge of active hsync: h_period <= h_ctr (saturated), h_ctr <= 1;
//   trailing edge: h_sync_len <= h_ctr. h_ctr saturates at all-ones; saturated value never equals a valid period.
// - V: v_ctr increments on each active hsync leading edge; on active vsync leading edge (taken at the
//   next hsync edge or same pix_stb) v_period <= v_ctr, v_ctr <= 1, new_frame pulses one clk.
// - Simultaneous hsync and vsync leading edge in same pix_stb: hsync updates first, then vsync uses
//   the incremented v_ctr (line counted).
// - H lock: new h_period within +-1 of previous and >=H_MIN and not saturated -> h_run++ (sat at H_LOCK_N),
//   else h_run<=0. V lock: v_period == previous, >=V_MIN, not saturated -> v_run++ else 0.
// - locked = (h_run==H_LOCK_N)&&(v_run==V_LOCK_N); drops in the clk after any mismatch.
// - Timeout: h_ctr saturates (no hsync edge for 2**H_W-1 pix_stb) -> h_run=0, v_run=0, locked=0,
//   h_period=0, v_period=0. v_ctr saturating likewise clears v_run and v_period.
// - pix_stb rate may change (TV/VGA); measurements are in pix_stb units, no clk-based timing.
// STRUCTURE
// - Shared include video_defs.vh: H_W/V_W, H_MIN/V_MIN, lock thresholds, polarity constants.
// - One sub-module: sync_period_meter (synchronizer, polarity vote, period/width counter, run-lock)
//   parameterised by width; instantiated for H (strobe=pix_stb) and V (strobe=hsync leading edge).
// - Top adds timeout cascade, lock AND and new_frame pulse; target 200-300 lines total.
// TESTING
// - TV timing, pix_stb every 4 clk, 448-period negative hsync low 33, 262 lines, vsync 2 lines neg
//   -> hsync_pol=0, vsync_pol=0, h_period=448, h_sync_len=33, v_period=262, locked=1 after 2 frames.
// - VGA: pix_stb every 2 clk, positive hsync, 448 period, sync 53, 524 lines -> pol=1/1, v_period=524, locked.
// - Invert hsync polarity mid-stream -> locked=0 within one pol window, hsync_pol flips, relock follows.
// - Stop hsync (held low) -> after 511 pix_stb locked=0, h_period=0, v_period=0; restart -> relock.
// - Jitter: periods alternating 448/449 -> locked stays 1; single 460 line -> locked=0, relock after 4 good lines.
// - Assert rst mid-frame -> all outputs 0 in same clk (async), resume measuring after release.

Source files
------------

// File: rtl/video_sync_detect_pkg.sv
// Shared timing defaults, lock thresholds and polarity encoding for the sync detector.
package video_sync_detect_pkg;

    localparam int unsigned DEF_H_W         = 9;
    localparam int unsigned DEF_V_W         = 10;
    localparam int unsigned DEF_POL_WIN_LOG = 10;
    localparam int unsigned DEF_H_MIN       = 64;
    localparam int unsigned DEF_V_MIN       = 128;
    localparam int unsigned DEF_H_LOCK_N    = 4;
    localparam int unsigned DEF_V_LOCK_N    = 2;
    localparam int unsigned H_TOL           = 1;
    localparam int unsigned V_TOL           = 0;

    typedef enum logic {
        POL_NEG = 1'b0,
        POL_POS = 1'b1
    } pol_e;

endpackage

// File: rtl/video_sync_detect_sync_period_meter.sv
// One sync channel: synchronizer, polarity vote, period/width counter and run-length lock.
module video_sync_detect_sync_period_meter
    import video_sync_detect_pkg::*;
#(
    parameter int unsigned W           = 9,
    parameter int unsigned POL_WIN_LOG = 10,
    parameter int unsigned MIN_PERIOD  = 64,
    parameter int unsigned TOL         = 1,
    parameter int unsigned LOCK_N      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stb,
    input  logic         sync_in,
    input  logic         clear,
    output logic         pol,
    output logic [W-1:0] period,
    output logic [W-1:0] sync_len,
    output logic         lead,
    output logic         pol_chg,
    output logic         sat,
    output logic         run_full
);

    localparam int unsigned CW    = POL_WIN_LOG + 1;
    localparam int unsigned RUN_W = $clog2(LOCK_N + 1);
    localparam logic [CW-1:0] HALF = CW'(2 ** (POL_WIN_LOG - 1));

    pol_e                   pol_q, pol_nxt;
    logic [2:0]             sync_q;
    logic                   rise_flag, fall_flag, pend_rise, pend_fall;
    logic                   trail, match, win_end;
    logic [POL_WIN_LOG-1:0] win;
    logic [CW-1:0]          hi_cnt, hi_next;
    logic [W-1:0]           ctr, diff;
    logic [RUN_W-1:0]       run;

    // Raw edges are latched until the next strobe so slow strobes never miss them.
    assign pend_rise = rise_flag | (sync_q[1] & ~sync_q[2]);
    assign pend_fall = fall_flag | (~sync_q[1] & sync_q[2]);
    assign lead      = stb & ((pol_q == POL_POS) ? pend_rise : pend_fall);
    assign trail     = stb & ((pol_q == POL_POS) ? pend_fall : pend_rise);
    assign sat       = (ctr == '1);
    assign pol       = (pol_q == POL_POS);
    assign run_full  = (run == RUN_W'(LOCK_N));

    always_comb begin
        diff    = (ctr >= period) ? (ctr - period) : (period - ctr);
        match   = !sat && (ctr >= W'(MIN_PERIOD)) && (diff <= W'(TOL));
        hi_next = hi_cnt + CW'(sync_q[1]);
        win_end = stb && (win == '1);
        pol_nxt = pol_q;
        if (hi_next < HALF) begin
            pol_nxt = POL_POS;
        end else if (hi_next > HALF) begin
            pol_nxt = POL_NEG;
        end
        pol_chg = win_end && (pol_nxt != pol_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            rise_flag <= 1'b0;
            fall_flag <= 1'b0;
            pol_q     <= POL_NEG;
            win       <= '0;
            hi_cnt    <= '0;
            ctr       <= '0;
            period    <= '0;
            sync_len  <= '0;
            run       <= '0;
        end else begin
            sync_q    <= {sync_q[1:0], sync_in};
            rise_flag <= stb ? 1'b0 : pend_rise;
            fall_flag <= stb ? 1'b0 : pend_fall;
            if (stb) begin
                win    <= win + 1'b1;
                hi_cnt <= win_end ? '0 : hi_next;
                if (win_end) begin
                    pol_q <= pol_nxt;
                end
                if (lead) begin
                    ctr <= W'(1);
                end else if (!sat) begin
                    ctr <= ctr + 1'b1;
                end
                if (trail && !lead) begin
                    sync_len <= ctr;
                end
            end
            if (clear || sat) begin
                period <= '0;
            end else if (lead) begin
                period <= ctr;
            end
            if (clear || sat || pol_chg) begin
                run <= '0;
            end else if (lead) begin
                run <= match ? (run_full ? run : run + 1'b1) : '0;
            end
        end
    end

endmodule

// File: rtl/video_sync_detect.sv
// External HSYNC/VSYNC analyser: polarity, line period, sync width, lines per frame and lock.
module video_sync_detect
    import video_sync_detect_pkg::*;
#(
    parameter int unsigned H_W         = DEF_H_W,
    parameter int unsigned V_W         = DEF_V_W,
    parameter int unsigned POL_WIN_LOG = DEF_POL_WIN_LOG,
    parameter int unsigned H_MIN       = DEF_H_MIN,
    parameter int unsigned V_MIN       = DEF_V_MIN,
    parameter int unsigned H_LOCK_N    = DEF_H_LOCK_N,
    parameter int unsigned V_LOCK_N    = DEF_V_LOCK_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_stb,
    input  logic           hsync_in,
    input  logic           vsync_in,
    output logic           hsync_pol,
    output logic           vsync_pol,
    output logic [H_W-1:0] h_period,
    output logic [H_W-1:0] h_sync_len,
    output logic [V_W-1:0] v_period,
    output logic           locked,
    output logic           new_frame
);

    logic           h_lead, h_sat, h_pol_chg, h_full;
    logic           v_lead, v_full;
    logic           v_pol_chg_unused, v_sat_unused;
    logic [V_W-1:0] v_sync_len_unused;

    video_sync_detect_sync_period_meter #(
        .W(H_W), .POL_WIN_LOG(POL_WIN_LOG), .MIN_PERIOD(H_MIN), .TOL(H_TOL), .LOCK_N(H_LOCK_N)
    ) u_h (
        .clk(clk), .rst(rst), .stb(pix_stb), .sync_in(hsync_in), .clear(1'b0),
        .pol(hsync_pol), .period(h_period), .sync_len(h_sync_len), .lead(h_lead),
        .pol_chg(h_pol_chg), .sat(h_sat), .run_full(h_full)
    );

    // Lines are the vertical strobe; losing hsync or its polarity invalidates frame data.
    video_sync_detect_sync_period_meter #(
        .W(V_W), .POL_WIN_LOG(POL_WIN_LOG), .MIN_PERIOD(V_MIN), .TOL(V_TOL), .LOCK_N(V_LOCK_N)
    ) u_v (
        .clk(clk), .rst(rst), .stb(h_lead), .sync_in(vsync_in), .clear(h_sat | h_pol_chg),
        .pol(vsync_pol), .period(v_period), .sync_len(v_sync_len_unused), .lead(v_lead),
        .pol_chg(v_pol_chg_unused), .sat(v_sat_unused), .run_full(v_full)
    );

    assign locked = h_full & v_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            new_frame <= 1'b0;
        end else begin
            new_frame <= v_lead;
        end
    end

endmodule

// File: tb/tb_video_sync_detect.sv
// Directed bench for video_sync_detect using scaled-down timings and counter widths.
module tb_video_sync_detect;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_stb, hsync_in, vsync_in;
    logic       hsync_pol, vsync_pol, locked, new_frame;
    logic [5:0] h_period, h_sync_len;
    logic [4:0] v_period;

    int unsigned errors = 0;
    int unsigned checks = 0;

    int unsigned stb_div  = 4;
    int unsigned h_len    = 24;
    int unsigned h_sync   = 3;
    int unsigned n_lines  = 12;
    int unsigned v_sync   = 2;
    logic        hpol     = 1'b0;
    logic        vpol     = 1'b0;
    logic        h_en     = 1'b1;
    logic        jit_en   = 1'b0;
    int unsigned bump_len = 0;

    video_sync_detect #(
        .H_W(6), .V_W(5), .POL_WIN_LOG(4), .H_MIN(8), .V_MIN(6), .H_LOCK_N(4), .V_LOCK_N(2)
    ) dut (
        .clk(clk), .rst(rst), .pix_stb(pix_stb), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hsync_pol(hsync_pol), .vsync_pol(vsync_pol), .h_period(h_period),
        .h_sync_len(h_sync_len), .v_period(v_period), .locked(locked), .new_frame(new_frame)
    );

    always #5 clk = ~clk;

    // Sync source: pins change only on strobe cycles; line start is the sync leading edge.
    initial begin
        int unsigned div_cnt = 0;
        int unsigned px = 0;
        int unsigned ln = 0;
        int unsigned cur_len = 24;
        logic        jit_tog = 1'b0;
        pix_stb  = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        forever begin
            @(negedge clk);
            if (div_cnt + 1 >= stb_div) begin
                div_cnt = 0;
                pix_stb = 1'b1;
                px++;
                if (px >= cur_len) begin
                    px = 0;
                    ln = (ln + 1 >= n_lines) ? 0 : ln + 1;
                    jit_tog = ~jit_tog;
                    if (bump_len != 0) begin
                        cur_len  = bump_len;
                        bump_len = 0;
                    end else begin
                        cur_len = h_len + ((jit_en && jit_tog) ? 1 : 0);
                    end
                end
                hsync_in = h_en ? ((px < h_sync) ~^ hpol) : 1'b0;
                vsync_in = (ln < v_sync) ~^ vpol;
            end else begin
                div_cnt++;
                pix_stb = 1'b0;
            end
        end
    end

    task automatic wait_locked(input logic want, input int unsigned max_clk,
                               output int unsigned took, output bit ok);
        ok   = 1'b0;
        took = 0;
        while (took < max_clk && !ok) begin
            @(negedge clk);
            took++;
            if (locked === want) ok = 1'b1;
        end
    endtask

    task automatic start_mode(input int unsigned div, input int unsigned len, input int unsigned sl,
                              input int unsigned lines, input int unsigned vs,
                              input logic hp, input logic vp, input logic jit);
        rst      = 1'b1;
        stb_div  = div;
        h_len    = len;
        h_sync   = sl;
        n_lines  = lines;
        v_sync   = vs;
        hpol     = hp;
        vpol     = vp;
        jit_en   = jit;
        h_en     = 1'b1;
        bump_len = 0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({hsync_pol, vsync_pol, locked, new_frame} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {hsync_pol, vsync_pol, locked, new_frame});
        end
        checks++;
        if (h_period !== 6'd0) begin
            errors++;
            $display("FAIL reset_h_period: got %0d expected 0", h_period);
        end
        checks++;
        if (h_sync_len !== 6'd0) begin
            errors++;
            $display("FAIL reset_h_sync_len: got %0d expected 0", h_sync_len);
        end
        checks++;
        if (v_period !== 5'd0) begin
            errors++;
            $display("FAIL reset_v_period: got %0d expected 0", v_period);
        end
    endtask

    task automatic test_tv();
        int unsigned took, pulses;
        bit ok;
        start_mode(4, 24, 3, 12, 2, 1'b0, 1'b0, 1'b0);
        wait_locked(1'b1, 12000, took, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tv_lock: locked=%0d after %0d clk, expected 1", locked, took);
        end
        checks++;
        if ({hsync_pol, vsync_pol} !== 2'b00) begin
            errors++;
            $display("FAIL tv_pol: got %b expected 00", {hsync_pol, vsync_pol});
        end
        checks++;
        if (h_period !== 6'd24) begin
            errors++;
            $display("FAIL tv_h_period: got %0d expected 24", h_period);
        end
        checks++;
        if (h_sync_len !== 6'd3) begin
            errors++;
            $display("FAIL tv_h_sync_len: got %0d expected 3", h_sync_len);
        end
        checks++;
        if (v_period !== 5'd12) begin
            errors++;
            $display("FAIL tv_v_period: got %0d expected 12", v_period);
        end
        pulses = 0;
        repeat (24 * 12 * 4) begin
            @(negedge clk);
            if (new_frame === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL tv_new_frame: got %0d pulses per frame expected 1", pulses);
        end
    endtask

    task automatic test_vga();
        int unsigned took;
        bit ok;
        start_mode(2, 30, 5, 14, 2, 1'b1, 1'b1, 1'b0);
        wait_locked(1'b1, 12000, took, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL vga_lock: locked=%0d after %0d clk, expected 1", locked, took);
        end
        checks++;
        if ({hsync_pol, vsync_pol} !== 2'b11) begin
            errors++;
            $display("FAIL vga_pol: got %b expected 11", {hsync_pol, vsync_pol});
        end
        checks++;
        if (h_period !== 6'd30 || h_sync_len !== 6'd5) begin
            errors++;
            $display("FAIL vga_h: got period %0d len %0d expected 30 5", h_period, h_sync_len);
        end
        checks++;
        if (v_period !== 5'd14) begin
            errors++;
            $display("FAIL vga_v_period: got %0d expected 14", v_period);
        end
    endtask

    task automatic test_pol_invert();
        int unsigned took;
        bit ok;
        hpol = 1'b0;
        wait_locked(1'b0, 200, took, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL inv_unlock: locked=%0d after %0d clk, expected 0", locked, took);
        end
        wait_locked(1'b1, 15000, took, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL inv_relock: locked=%0d after %0d clk, expected 1", locked, took);
        end
        checks++;
        if ({hsync_pol, vsync_pol} !== 2'b01) begin
            errors++;
            $display("FAIL inv_pol: got %b expected 01", {hsync_pol, vsync_pol});
        end
        checks++;
        if (h_period !== 6'd30 || h_sync_len !== 6'd5) begin
            errors++;
            $display("FAIL inv_h: got period %0d len %0d expected 30 5", h_period, h_sync_len);
        end
    endtask

    task automatic test_jitter();
        int unsigned took, drops;
        bit ok;
        start_mode(2, 30, 5, 14, 2, 1'b1, 1'b1, 1'b1);
        wait_locked(1'b1, 12000, took, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL jit_lock: locked=%0d after %0d clk, expected 1", locked, took);
        end
        drops = 0;
        repeat (2 * 14 * 31 * 2) begin
            @(negedge clk);
            if (locked !== 1'b1) drops++;
        end
        checks++;
        if (drops != 0) begin
            errors++;
            $display("FAIL jit_hold: locked low for %0d clk expected 0", drops);
        end
        checks++;
        if (h_period !== 6'd30 && h_period !== 6'd31) begin
            errors++;
            $display("FAIL jit_h_period: got %0d expected 30 or 31", h_period);
        end
        bump_len = 40;
        wait_locked(1'b0, 300, took, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bump_unlock: locked=%0d after %0d clk, expected 0", locked, took);
        end
        wait_locked(1'b1, 800, took, ok);
        checks++;
        if (!ok || took < 240) begin
            errors++;
            $display("FAIL bump_relock: locked=%0d after %0d clk, expected 1 after >=240", locked, took);
        end
    endtask

    task automatic test_stop();
        int unsigned took;
        bit ok;
        jit_en = 1'b0;
        h_en   = 1'b0;
        repeat (200) @(negedge clk);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL stop_locked: got %0d expected 0", locked);
        end
        checks++;
        if (h_period !== 6'd0 || v_period !== 5'd0) begin
            errors++;
            $display("FAIL stop_periods: got h %0d v %0d expected 0 0", h_period, v_period);
        end
        h_en = 1'b1;
        wait_locked(1'b1, 15000, took, ok);
        checks++;
        if (!ok || h_period !== 6'd30) begin
            errors++;
            $display("FAIL stop_relock: locked=%0d h_period=%0d expected 1 30", locked, h_period);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned took;
        bit ok;
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_lock: got %0d expected 1", locked);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({hsync_pol, vsync_pol, h_period, h_sync_len, v_period, locked, new_frame} !== '0) begin
            errors++;
            $display("FAIL mid_async_clear: got pol %b%b h %0d len %0d v %0d lock %0d nf %0d expected all 0",
                     hsync_pol, vsync_pol, h_period, h_sync_len, v_period, locked, new_frame);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_locked(1'b1, 12000, took, ok);
        checks++;
        if (!ok || v_period !== 5'd14) begin
            errors++;
            $display("FAIL mid_relock: locked=%0d v_period=%0d expected 1 14", locked, v_period);
        end
    endtask

    task automatic test_short_period();
        int unsigned took;
        bit ok;
        start_mode(2, 7, 2, 12, 2, 1'b1, 1'b1, 1'b0);
        repeat (2100) @(negedge clk);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL short_locked: got %0d expected 0", locked);
        end
        checks++;
        if (h_period !== 6'd7 || v_period !== 5'd12) begin
            errors++;
            $display("FAIL short_periods: got h %0d v %0d expected 7 12", h_period, v_period);
        end
        h_len = 8;
        wait_locked(1'b1, 3000, took, ok);
        checks++;
        if (!ok || h_period !== 6'd8) begin
            errors++;
            $display("FAIL min_period_lock: locked=%0d h_period=%0d expected 1 8", locked, h_period);
        end
    endtask

    initial begin
        test_reset();
        test_tv();
        test_vga();
        test_pol_invert();
        test_jitter();
        test_stop();
        test_reset_mid();
        test_short_period();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
